// File: rtl/regfile_multiport_pkg.sv
// ============================================================================
// Module      : regfile_multiport_pkg
// Description : Shared constants for the multi-port register file: the ISA
//               data width and register-file address width used as parameter
//               defaults, and the hardwired zero-register address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_multiport_pkg;

  // Architectural data width of the integer register file.
  localparam int ISA_XLEN      = 32;

  // Register-file address width (32 architectural registers).
  localparam int RF_ADDR_WIDTH = 5;

  // Address of the hardwired zero register.
  localparam int REG_ZERO      = 0;

endpackage : regfile_multiport_pkg

`default_nettype wire

// File: rtl/regfile_multiport_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy scoreboard for pipeline hazard detection.
//               Issue sets a busy bit, committed writebacks clear it; when
//               both hit the same register in one cycle the set wins because
//               the newly issued producer supersedes the old one. Also keeps
//               a registered popcount of the busy vector.
// Ports       : clk, rst_n           clock / synchronous active-high reset
//               wr0_commit_i/addr_i  write port 0 commit and address
//               wr1_commit_i/addr_i  write port 1 commit and address
//               issue_en_i/addr_i    issue marking of a destination register
//               busy_o               busy bit vector (bit 0 always 0)
//               busy_count_o         number of busy registers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_multiport_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr0_commit_i,
  input  logic [ADDR_WIDTH-1:0]   wr0_addr_i,
  input  logic                    wr1_commit_i,
  input  logic [ADDR_WIDTH-1:0]   wr1_addr_i,
  input  logic                    issue_en_i,
  input  logic [ADDR_WIDTH-1:0]   issue_addr_i,
  output logic [2**ADDR_WIDTH-1:0] busy_o,
  output logic [ADDR_WIDTH:0]     busy_count_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0]    busy_q;
  logic [DEPTH-1:0]    busy_d;
  logic [ADDR_WIDTH:0] busy_count_q;
  logic [ADDR_WIDTH:0] busy_count_d;

  // Clears are applied first and the issue set last, so set wins on a
  // same-address collision. Setting an already-busy bit is idempotent and
  // clearing an idle bit is harmless, so the popcount can never double-count
  // or underflow.
  always_comb begin
    busy_d = busy_q;
    if (wr0_commit_i) begin
      busy_d[wr0_addr_i] = 1'b0;
    end
    if (wr1_commit_i) begin
      busy_d[wr1_addr_i] = 1'b0;
    end
    if (issue_en_i && (int'(issue_addr_i) != REG_ZERO)) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Count is taken from next-state bits so it tracks the busy vector in the
  // same cycle rather than lagging it by one.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = busy_count_q;

endmodule : regfile_scoreboard

`default_nettype wire

// File: rtl/regfile_multiport.sv
// ============================================================================
// Module      : regfile_multiport
// Description : Parametrised register file with NUM_READ combinational read
//               ports, two prioritised write ports (wr1 wins), a hardwired
//               zero register and a busy scoreboard for hazard detection.
//               Optional macro REGFILE_BYPASS_EN forwards same-cycle write
//               data (wr1 over wr0) to the read ports; when undefined, writes
//               become visible on the cycle after they commit.
// Ports       : clk, rst_n         clock / synchronous reset (active-high)
//               wr0_en/addr/data   write port 0 (WB stage)
//               wr1_en/addr/data   write port 1 (early writeback)
//               issue_en/addr      destination marking at issue
//               rd_addr            packed read addresses, ADDR_WIDTH per port
//               rd_data            packed read data, DATA_WIDTH per port
//               rd_busy            busy flag per read port
//               busy_count         number of busy registers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_WIDTH = ISA_XLEN,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr0_en,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic                           wr1_en,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr,
  input  logic [DATA_WIDTH-1:0]          wr1_data,
  input  logic                           issue_en,
  input  logic [ADDR_WIDTH-1:0]          issue_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  output logic [ADDR_WIDTH:0]            busy_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic                  w_wr0_commit;
  logic                  w_wr1_commit;
  logic [DEPTH-1:0]      w_busy;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // A write to the zero register is not a commit: it neither stores data
  // nor clears busy state.
  assign w_wr0_commit = wr0_en && (int'(wr0_addr) != REG_ZERO);
  assign w_wr1_commit = wr1_en && (int'(wr1_addr) != REG_ZERO);

  // wr1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w_wr0_commit) begin
        mem_q[wr0_addr] <= wr0_data;
      end
      if (w_wr1_commit) begin
        mem_q[wr1_addr] <= wr1_data;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr0_commit_i (w_wr0_commit),
    .wr0_addr_i   (wr0_addr),
    .wr1_commit_i (w_wr1_commit),
    .wr1_addr_i   (wr1_addr),
    .issue_en_i   (issue_en),
    .issue_addr_i (issue_addr),
    .busy_o       (w_busy),
    .busy_count_o (busy_count)
  );

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_busy_rd;

    assign w_addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_data    = mem_q[w_addr];
      w_busy_rd = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      // Commit signals already exclude the zero register, so r0 is never
      // forwarded. wr1 is checked last to take priority over wr0.
      if (w_wr0_commit && (wr0_addr == w_addr)) begin
        w_data = wr0_data;
      end
      if (w_wr1_commit && (wr1_addr == w_addr)) begin
        w_data = wr1_data;
      end
      // A committing write resolves the hazard this cycle unless a new
      // producer for the same register is issuing alongside it.
      if (((w_wr0_commit && (wr0_addr == w_addr)) ||
           (w_wr1_commit && (wr1_addr == w_addr))) &&
          !(issue_en && (issue_addr == w_addr))) begin
        w_busy_rd = 1'b0;
      end
`endif
      if (int'(w_addr) == REG_ZERO) begin
        w_data    = '0;
        w_busy_rd = 1'b0;
      end
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign rd_busy[k]                          = w_busy_rd;
  end : g_read

endmodule : regfile_multiport

`default_nettype wire

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, dual-read CPU register file.
- Provides a configurable read-port count, two prioritised write ports, a hardwired zero register, and a per-register busy scoreboard for pipeline hazard detection.
- Sits between the ID stage (reads, issue marking) and the MEM/WB stages (writebacks).
- All state updates on the rising clock edge.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of independent read ports (1..4).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  synchronous reset, active-high despite the name.
- wr0_en  in  1  write port 0 enable (WB stage).
- wr0_addr  in  ADDR_WIDTH  write port 0 address.
- wr0_data  in  DATA_WIDTH  write port 0 data.
- wr1_en  in  1  write port 1 enable (early/MEM-bypass writeback).
- wr1_addr  in  ADDR_WIDTH  write port 1 address.
- wr1_data  in  DATA_WIDTH  write port 1 data.
- issue_en  in  1  mark issue_addr busy (instruction issued with destination).
- issue_addr  in  ADDR_WIDTH  destination register being issued.
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data.
- rd_busy  out  NUM_READ  busy flag of each read address.
- busy_count  out  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset is synchronous and active-high.
  - rst_n=1 at a posedge clears all registers to 0, all busy bits to 0, and busy_count to 0.
  - Reset overrides every write and issue in the same cycle.
  - Reset asserted mid-operation discards in-flight issues; their later writebacks still write data normally and leave busy at 0.
- Reads are combinational from the array (0 latency).
  - Address 0 always returns 0 and rd_busy=0.
- Writes are committed at posedge when wrX_en=1 and wrX_addr!=0.
  - Writes to address 0 are ignored.
  - wr0 and wr1 to the same nonzero address in one cycle: wr1 wins.
- Scoreboard:
  - A posedge with issue_en=1 and issue_addr!=0 sets busy[issue_addr].
  - Any committed write clears busy[wrX_addr].
  - Issue and write to the same address in the same cycle: set wins, because the new producer supersedes.
  - Issue of an already-busy register: stays busy; busy_count does not double-count.
  - Write to a non-busy register: busy stays 0, no underflow.
- busy_count is a registered popcount of the busy bits. It reflects state after the edge, so it is updated in the same cycle as the busy vector.
- Read/write on the same address in the same cycle, without the feature: rd_data returns the old value; the new value is visible from the next cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data combinationally.
  - Match on wr1 takes priority over wr0; address 0 is never forwarded.
  - rd_busy is forced to 0 when the read address matches a committing write and no same-cycle issue targets it.
- Undefined: pure array read, one-cycle write-to-read visibility as above.

Decomposition:
- Shared package/definitions file holds:
  - the existing ISA width and register-file address-width constants, used as parameter defaults;
  - a REG_ZERO address constant.
- One natural sub-module: regfile_scoreboard, containing the busy bit vector, the set/clear priority and busy_count.
- Data array and read muxing/forwarding stay in the top module.

Test Plan:
- Reset: write 0xDEAD_BEEF to r5, assert rst_n one cycle → r5 reads 0, all rd_busy=0, busy_count=0.
- Zero register: wr0 to r0 with 0x1234, issue r0 → rd_data for r0 = 0, busy_count stays 0.
- Write collision: wr0 r7=0x11, wr1 r7=0x22 in the same cycle → next cycle r7 reads 0x22.
- Scoreboard:
  - issue r3 → busy_count=1 and rd_busy=1 for r3;
  - later issue r3 together with wr0 r3=0x55 → r3=0x55, still busy, count=1;
  - then wr1 r3 alone → busy 0, count 0.
- Bypass: read r9 while wr0 r9=0xCAFE.
  - REGFILE_BYPASS_EN defined → rd_data=0xCAFE in the same cycle.
  - Undefined → old value, 0xCAFE on the next cycle.
- NUM_READ=4: four ports reading r1..r4 (values 1..4) simultaneously → each lane returns its own value, no lane crosstalk.
